// File: rtl/user_id_serializer.sv
// Hardwired user ID words with a bit-serial valid/ready readout engine; word 0 also drives mask_rev.
// Optional macro USER_ID_OVERRIDE_EN adds a lockable runtime override of word 0.
module user_id_serializer #(
    parameter int                          WIDTH     = 32,
    parameter int                          NUM_WORDS = 2,
    parameter logic [WIDTH*NUM_WORDS-1:0]  ID_VALUE  = {WIDTH*NUM_WORDS{1'b0}},
    parameter bit                          MSB_FIRST = 1'b1,
    parameter int                          IDXW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rstn_i,
`ifdef USER_ID_OVERRIDE_EN
    input  logic [WIDTH-1:0] ovr_wdata,
    input  logic             ovr_we,
    input  logic             ovr_lock,
`endif
    output logic [WIDTH-1:0] mask_rev,
    input  logic             rd_req,
    input  logic [IDXW-1:0]  rd_idx,
    output logic             rd_busy,
    output logic             sdo,
    output logic             sdo_valid,
    input  logic             sdo_ready,
    output logic             rd_done,
    output logic             rd_err,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             err_q, err_nxt;
    logic [WIDTH-1:0] word0;
    logic [WIDTH-1:0] load_word;
    logic [31:0]      idx_ext;
    logic             idx_ok;

`ifdef USER_ID_OVERRIDE_EN
    logic [WIDTH-1:0] ovr_reg;
    logic             ovr_valid;
    logic             locked;

    // A write in the same cycle as lock still lands; lock only blocks later writes.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ovr_reg   <= '0;
            ovr_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            if (ovr_we && !locked) begin
                ovr_reg   <= ovr_wdata;
                ovr_valid <= 1'b1;
            end
            if (ovr_lock) begin
                locked <= 1'b1;
            end
        end
    end

    assign word0 = ovr_valid ? ovr_reg : ID_VALUE[WIDTH-1:0];
`else
    assign word0 = ID_VALUE[WIDTH-1:0];
`endif

    assign mask_rev = word0;

    assign idx_ext = 32'(rd_idx);
    assign idx_ok  = (idx_ext < 32'(NUM_WORDS));

    always_comb begin
        load_word = word0;
        for (int i = 1; i < NUM_WORDS; i++) begin
            if (idx_ext == 32'(i)) begin
                load_word = ID_VALUE[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state <= S_IDLE;
            sr    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_req) begin
                    if (idx_ok) begin
                        sr_nxt    = load_word;
                        cnt_nxt   = CW'(WIDTH - 1);
                        state_nxt = S_SHIFT;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // sdo_valid is always high here, so ready alone completes the handshake.
                if (sdo_ready) begin
                    sr_nxt = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
                    if (cnt == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sdo_valid = (state == S_SHIFT);
    assign sdo       = sdo_valid & (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    assign rd_busy   = (state != S_IDLE);
    assign rd_done   = (state == S_DONE);
    assign rd_err    = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_user_id_serializer.sv
// Directed bench for user_id_serializer: two instances (2 words MSB-first, 3 words LSB-first).
// Covers reset state, readout with/without stalls, range error, ignored requests, reset abort, override.
module tb_user_id_serializer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_WORDS=2, MSB first
    logic         rd_req = 1'b0;
    logic [0:0]   rd_idx = '0;
    logic         sdo_ready = 1'b0;
    logic [W-1:0] mask_rev;
    logic         rd_busy, sdo, sdo_valid, rd_done, rd_err;
    logic [1:0]   dbg_state;

    // Instance B: NUM_WORDS=3, LSB first
    logic         req3 = 1'b0;
    logic [1:0]   idx3 = '0;
    logic         ready3 = 1'b1;
    logic [W-1:0] mask3;
    logic         busy3, sdo3, valid3, done3, err3;
    logic [1:0]   dbg3;

`ifdef USER_ID_OVERRIDE_EN
    logic [W-1:0] ovr_wdata = '0;
    logic         ovr_we = 1'b0;
    logic         ovr_lock = 1'b0;
    logic [W-1:0] z_wdata = '0;
    logic         z_we = 1'b0;
    logic         z_lock = 1'b0;
`endif

    user_id_serializer #(
        .WIDTH(W), .NUM_WORDS(2),
        .ID_VALUE({32'hCAFE0001, 32'hA5A500F0}),
        .MSB_FIRST(1'b1)
    ) u_dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
`ifdef USER_ID_OVERRIDE_EN
        .ovr_wdata(ovr_wdata), .ovr_we(ovr_we), .ovr_lock(ovr_lock),
`endif
        .mask_rev(mask_rev), .rd_req(rd_req), .rd_idx(rd_idx), .rd_busy(rd_busy),
        .sdo(sdo), .sdo_valid(sdo_valid), .sdo_ready(sdo_ready),
        .rd_done(rd_done), .rd_err(rd_err), .dbg_state(dbg_state)
    );

    user_id_serializer #(
        .WIDTH(W), .NUM_WORDS(3),
        .ID_VALUE({32'h11112222, 32'hCAFE0001, 32'hA5A500F0}),
        .MSB_FIRST(1'b0)
    ) u_dut3 (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
`ifdef USER_ID_OVERRIDE_EN
        .ovr_wdata(z_wdata), .ovr_we(z_we), .ovr_lock(z_lock),
`endif
        .mask_rev(mask3), .rd_req(req3), .rd_idx(idx3), .rd_busy(busy3),
        .sdo(sdo3), .sdo_valid(valid3), .sdo_ready(ready3),
        .rd_done(done3), .rd_err(err3), .dbg_state(dbg3)
    );

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [0:0] exp_q[$];

    always @(posedge clk) if (rd_done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 of the request cycle; ends at posedge+1 two cycles after DONE.
    task automatic read_word(input logic idx, input logic [31:0] word, input bit rnd, input bit poke);
        int cyc;
        int got;
        int d0;
        bit stalled;
        logic pbit;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
        d0 = done_cnt;
        rd_req = 1'b1;
        rd_idx = idx;
        sdo_ready = 1'b1;
        @(negedge clk);
        chk("req_cycle_valid", {31'd0, sdo_valid}, 32'd0);
        step();
        rd_req = 1'b0;
        cyc = 0;
        got = 0;
        stalled = 1'b0;
        pbit = 1'b0;
        while (got < W && cyc < 400) begin
            if (poke && cyc == 5) begin
                rd_req = 1'b1;
                rd_idx = 1'b0;
            end else begin
                rd_req = 1'b0;
            end
            sdo_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", {31'd0, sdo_valid}, 32'd1);
                chk("stall_sdo", {31'd0, sdo}, {31'd0, pbit});
            end
            if (sdo_valid && sdo_ready) begin
                chk("sdo_bit", {31'd0, sdo}, {31'd0, exp_q.pop_front()});
                got++;
                stalled = 1'b0;
            end else if (sdo_valid) begin
                stalled = 1'b1;
                pbit = sdo;
            end
            step();
            cyc++;
        end
        rd_req = 1'b0;
        chk("handshakes", got, W);
        chk("queue_empty", exp_q.size(), 0);
        if (!rnd) chk("latency", cyc, W);
        exp_q.delete();
        @(negedge clk);
        chk("rd_done", {31'd0, rd_done}, 32'd1);
        chk("done_valid", {31'd0, sdo_valid}, 32'd0);
        chk("done_busy", {31'd0, rd_busy}, 32'd1);
        step();
        @(negedge clk);
        chk("done_end", {31'd0, rd_done}, 32'd0);
        chk("idle_busy", {31'd0, rd_busy}, 32'd0);
        chk("done_count", done_cnt - d0, 1);
        step();
    endtask

    initial begin
        int d0;
        sdo_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mask_in_reset", mask_rev, 32'hA5A500F0);
        chk("valid_in_reset", {31'd0, sdo_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mask", mask_rev, 32'hA5A500F0);
        chk("rst_valid", {31'd0, sdo_valid}, 32'd0);
        chk("rst_busy", {31'd0, rd_busy}, 32'd0);
        chk("rst_done", {31'd0, rd_done}, 32'd0);
        chk("rst_err", {31'd0, rd_err}, 32'd0);
        chk("rst_sdo", {31'd0, sdo}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_mask3", mask3, 32'hA5A500F0);
        step();

        read_word(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
        read_word(1'b1, 32'hCAFE0001, 1'b1, 1'b1);
        read_word(1'b0, 32'hA5A500F0, 1'b0, 1'b1);

        // Out-of-range index on the 3-word instance
        req3 = 1'b1;
        idx3 = 2'd3;
        step();
        req3 = 1'b0;
        @(negedge clk);
        chk("err3_pulse", {31'd0, err3}, 32'd1);
        chk("err3_valid", {31'd0, valid3}, 32'd0);
        step();
        @(negedge clk);
        chk("err3_end", {31'd0, err3}, 32'd0);
        chk("err3_valid2", {31'd0, valid3}, 32'd0);
        chk("err3_busy", {31'd0, busy3}, 32'd0);
        step();

        // LSB-first readout of word 2 on the 3-word instance
        req3 = 1'b1;
        idx3 = 2'd2;
        step();
        req3 = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("lsb_valid", {31'd0, valid3}, 32'd1);
            chk("lsb_bit", {31'd0, sdo3}, {31'd0, (32'h11112222 >> i) & 32'd1 ? 1'b1 : 1'b0});
            step();
        end
        @(negedge clk);
        chk("lsb_done", {31'd0, done3}, 32'd1);
        chk("lsb_err", {31'd0, err3}, 32'd0);
        step();

        // Reset after 10 accepted bits
        rd_req = 1'b1;
        rd_idx = 1'b1;
        sdo_ready = 1'b1;
        step();
        rd_req = 1'b0;
        repeat (10) step();
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, sdo_valid}, 32'd0);
        chk("abort_busy", {31'd0, rd_busy}, 32'd0);
        chk("abort_sdo", {31'd0, sdo}, 32'd0);
        chk("abort_mask", mask_rev, 32'hA5A500F0);
        step();
        step();
        rst_n = 1'b1;
        repeat (40) step();
        chk("abort_no_done", done_cnt - d0, 0);
        read_word(1'b1, 32'hCAFE0001, 1'b0, 1'b0);

`ifdef USER_ID_OVERRIDE_EN
        ovr_wdata = 32'h12345678;
        ovr_we = 1'b1;
        step();
        ovr_we = 1'b0;
        @(negedge clk);
        chk("ovr_mask", mask_rev, 32'h12345678);
        step();
        ovr_lock = 1'b1;
        step();
        ovr_lock = 1'b0;
        ovr_wdata = 32'hFFFFFFFF;
        ovr_we = 1'b1;
        step();
        ovr_we = 1'b0;
        @(negedge clk);
        chk("ovr_locked_mask", mask_rev, 32'h12345678);
        step();
        read_word(1'b0, 32'h12345678, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/user_id_serializer.md
Name: user_id_serializer

Overview:
- Parametrised successor to the fixed user project ID block.
- Holds NUM_WORDS hardwired ID words; word 0 drives the static mask_rev output as before.
- Adds a serial readout engine: any word can be streamed bit-serially over a valid/ready link to housekeeping, so the ID can be read over a narrow path.

Parameters:
- WIDTH, 32, bits per ID word (>=2).
- NUM_WORDS, 2, number of ID words (>=1).
- ID_VALUE, {WIDTH*NUM_WORDS{1'b0}}, packed constant; word i is ID_VALUE[i*WIDTH +: WIDTH].
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first, 0 = bit 0 first.
- IDXW, (NUM_WORDS>1 ? $clog2(NUM_WORDS) : 1), index width (derived, not overridden).

Ports:
- wb_clk_i  in  1  single clock; all state on rising edge.
- wb_rstn_i  in  1  reset, asynchronous assert, active-low; deassertion is pre-synchronised upstream.
- mask_rev  out  WIDTH  ID word 0 (or override, see Optional Feature).
- rd_req  in  1  start readout; sampled only in IDLE.
- rd_idx  in  IDXW  word index, sampled with rd_req.
- rd_busy  out  1  high in SHIFT and DONE.
- sdo  out  1  serial data bit.
- sdo_valid  out  1  sdo holds a valid bit.
- sdo_ready  in  1  consumer accepts bit.
- rd_done  out  1  one-cycle pulse when the last bit is accepted.
- rd_err  out  1  one-cycle pulse for an out-of-range index.

Behaviour:
- Reset (wb_rstn_i low, async): state=IDLE, shift register=0, bit counter=0, sdo=0, sdo_valid=0, rd_busy=0, rd_done=0, rd_err=0; mask_rev = word 0 at all times, including during reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, rd_req=1, rd_idx<NUM_WORDS:
  - Load the shift register with word rd_idx.
  - Set the counter to WIDTH-1.
  - Go to SHIFT. sdo_valid rises in the cycle after rd_req (latency 1).
- IDLE, rd_req=1, rd_idx>=NUM_WORDS:
  - rd_err=1 for exactly the next cycle; stay IDLE; no data is emitted.
- SHIFT:
  - sdo_valid=1.
  - sdo = shift register MSB when MSB_FIRST=1, else LSB.
  - On sdo_valid&sdo_ready: shift by one and decrement the counter.
  - If the counter was 0 at that handshake, go to DONE.
  - With ready low, sdo and sdo_valid are held stable (no drop, no change).
- DONE: sdo_valid=0, rd_done=1 for one cycle, then IDLE. A new rd_req is accepted on the cycle after DONE.
- Throughput: with sdo_ready tied high, exactly WIDTH valid cycles; rd_done is high in cycle N+WIDTH+1 for rd_req in cycle N.
- rd_req while rd_busy=1: ignored; no queueing and no error.
- Reset mid-stream: immediate abort to IDLE; no rd_done; the partial word is discarded.
- sdo is 0 whenever sdo_valid=0.
- NUM_WORDS=1: IDXW=1; rd_idx=1 produces rd_err.

Optional Feature:
- Macro: USER_ID_OVERRIDE_EN.
- Defined: adds three ports:
  - ovr_wdata in WIDTH
  - ovr_we in 1
  - ovr_lock in 1
- Defined, behaviour:
  - WIDTH-bit override register plus ovr_valid and locked flops, all reset to 0.
  - ovr_we=1 while unlocked: register = ovr_wdata and ovr_valid=1 at the next edge.
  - ovr_lock=1: locked=1, sticky until reset. Once locked, ovr_we is ignored.
  - Simultaneous ovr_we and ovr_lock while unlocked: the write takes effect, then the block locks.
  - When ovr_valid=1, mask_rev and serial readout of word 0 use the override value. A write during an active readout affects only later readouts.
- Undefined: ports are absent and mask_rev is purely the constant word 0.

Test Plan:
- Common setup: WIDTH=32, NUM_WORDS=2, ID_VALUE={32'hCAFE0001, 32'hA5A500F0}.
- Reset release -> mask_rev=32'hA5A500F0; sdo_valid, rd_busy, rd_done and rd_err all 0.
- rd_req with rd_idx=1, sdo_ready=1, MSB_FIRST=1 -> 32 valid bits forming 32'hCAFE0001 MSB first; rd_done pulses once at cycle N+33.
- Same readout with sdo_ready toggled randomly -> sdo is stable while stalled; bit sequence unchanged; exactly 32 handshakes.
- NUM_WORDS=3, rd_idx=3 -> rd_err high one cycle, no sdo_valid. Then rd_req mid-stream -> ignored.
- wb_rstn_i asserted after 10 bits of a readout -> outputs 0 the same cycle, no rd_done; a fresh readout after release is correct.
- With USER_ID_OVERRIDE_EN: write 32'h12345678 then lock, then write 32'hFFFFFFFF -> mask_rev=32'h12345678 and readout of word 0 streams 32'h12345678.
